// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//
// Shares the processor's single unified memory port between the fetch
// stage (instruction reads) and the execute stage (data loads/stores).
// Only one transaction is in flight at a time. A read waits out the fixed
// memory latency in I_WAIT or D_WAIT, and its returning data is routed back
// to whichever stage issued it. Data accesses have priority, but after
// STARVE_MAX consecutive denials a pending fetch is forced ahead of data.
// A flush discards the data of an in-flight fetch.
//
// Ports:
//   clk, reset                 clock and synchronous active-high reset
//   i_req/i_addr               fetch read request and address
//   i_gnt/i_rvalid/i_rdata     fetch accept pulse, read data valid pulse, data
//   d_req/d_we/d_addr/d_wdata  data request (d_we=1 store, 0 load)
//   d_gnt/d_rvalid/d_rdata     data accept pulse, load data valid pulse, data
//   flush                      pipeline redirect; kills fetch data only
//   m_req/m_we/m_addr/m_wdata  memory access strobe and payload
//   m_rdata                    memory read data, valid MEM_LAT cycles after strobe
//   busy                       a read is in flight
module mem_port_arbiter #(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int MEM_LAT    = 2,
   parameter int STARVE_MAX = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              i_req,
   input  logic [ADDR_W-1:0] i_addr,
   output logic              i_gnt,
   output logic              i_rvalid,
   output logic [DATA_W-1:0] i_rdata,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic              d_gnt,
   output logic              d_rvalid,
   output logic [DATA_W-1:0] d_rdata,
   input  logic              flush,
   output logic              m_req,
   output logic              m_we,
   output logic [ADDR_W-1:0] m_addr,
   output logic [DATA_W-1:0] m_wdata,
   input  logic [DATA_W-1:0] m_rdata,
   output logic              busy
);

   typedef enum logic [1:0] {IDLE, I_WAIT, D_WAIT} state_t;

   localparam logic [2:0] LAT_LOAD   = 3'(MEM_LAT - 1);
   localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

   state_t     state_q, state_d;
   logic [2:0] latCnt_q, latCnt_d;
   logic [3:0] starveCnt_q, starveCnt_d;
   logic       kill_q, kill_d;

   logic done;
   logic arbOk;
   logic iWant;
   logic forceI;
   logic grantD;
   logic grantI;

   // A wait state completes when its latency counter has reached zero; that
   // same cycle may already issue the next access, giving back-to-back reads.
   // A flushed fetch request is treated as absent for arbitration and for the
   // starvation count, so a flush alongside both requests lets D win cleanly.
   assign done   = (state_q != IDLE) && (latCnt_q == 3'd0);
   assign arbOk  = (state_q == IDLE) || done;
   assign iWant  = i_req & ~flush;
   assign forceI = (starveCnt_q == STARVE_LIM);
   assign grantD = arbOk & d_req & ~(forceI & iWant);
   assign grantI = arbOk & ~grantD & iWant;

   // Outputs are purely combinational from the current state and the
   // arbitration decision, and are all held at zero while reset is high so
   // nothing leaks to the memory or the pipeline during reset.
   always_comb begin
      i_gnt    = 1'b0;
      i_rvalid = 1'b0;
      i_rdata  = '0;
      d_gnt    = 1'b0;
      d_rvalid = 1'b0;
      d_rdata  = '0;
      m_req    = 1'b0;
      m_we     = 1'b0;
      m_addr   = '0;
      m_wdata  = '0;
      busy     = 1'b0;
      if (!reset) begin
         busy     = (state_q != IDLE);
         d_rvalid = done && (state_q == D_WAIT);
         i_rvalid = done && (state_q == I_WAIT) && !kill_q && !flush;
         if (d_rvalid) begin
            d_rdata = m_rdata;
         end
         if (i_rvalid) begin
            i_rdata = m_rdata;
         end
         i_gnt = grantI;
         d_gnt = grantD;
         m_req = grantD | grantI;
         if (grantD) begin
            m_we    = d_we;
            m_addr  = d_addr;
            m_wdata = d_wdata;
         end else if (grantI) begin
            m_addr = i_addr;
         end
      end
   end

   // Next-state logic. Stores finish on their grant edge and return to IDLE;
   // reads park in a wait state for MEM_LAT cycles. The starvation counter
   // only moves in cycles where arbitration actually happens, and the kill
   // flag lives only as long as the fetch it belongs to.
   always_comb begin
      state_d     = state_q;
      latCnt_d    = latCnt_q;
      starveCnt_d = starveCnt_q;
      kill_d      = 1'b0;
      if ((state_q != IDLE) && !done) begin
         latCnt_d = latCnt_q - 3'd1;
      end
      if (arbOk) begin
         state_d = IDLE;
         if (grantD && !d_we) begin
            state_d  = D_WAIT;
            latCnt_d = LAT_LOAD;
         end else if (grantI) begin
            state_d  = I_WAIT;
            latCnt_d = LAT_LOAD;
         end
         if (grantI) begin
            starveCnt_d = 4'd0;
         end else if (grantD && iWant && (starveCnt_q != STARVE_LIM)) begin
            starveCnt_d = starveCnt_q + 4'd1;
         end
      end
      if ((state_q == I_WAIT) && !done) begin
         kill_d = kill_q | flush;
      end
   end

   // State register; reset abandons any read in flight, so late memory data
   // finds the arbiter in IDLE and is ignored.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         latCnt_q    <= 3'd0;
         starveCnt_q <= 4'd0;
         kill_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         latCnt_q    <= latCnt_d;
         starveCnt_q <= starveCnt_d;
         kill_q      <= kill_d;
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//
// Cycle-by-cycle directed vectors for mem_port_arbiter with MEM_LAT=2 and
// STARVE_MAX=3, followed by two hand-written multi-cycle sequences
// (back-to-back load throughput and a bounded read-latency measurement).
module tb_mem_port_arbiter;

   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;

   // Expected-flag bit positions: {i_gnt,i_rvalid,d_gnt,d_rvalid,m_req,m_we,busy}
   localparam logic [6:0] F_IG = 7'b1000000;
   localparam logic [6:0] F_IR = 7'b0100000;
   localparam logic [6:0] F_DG = 7'b0010000;
   localparam logic [6:0] F_DR = 7'b0001000;
   localparam logic [6:0] F_MR = 7'b0000100;
   localparam logic [6:0] F_MW = 7'b0000010;
   localparam logic [6:0] F_BZ = 7'b0000001;

   typedef struct {
      logic        rst;
      logic        iReq;
      logic [31:0] iAddr;
      logic        dReq;
      logic        dWe;
      logic [31:0] dAddr;
      logic [31:0] dWdata;
      logic        flush;
      logic [31:0] mRdata;
      logic [6:0]  expFlags;
      logic [31:0] expAddr;
      logic [31:0] expWdata;
      logic [31:0] expRdata;
      logic [3:0]  expStarve;
   } vec_t;

   logic              clk;
   logic              reset;
   logic              i_req;
   logic [ADDR_W-1:0] i_addr;
   logic              i_gnt;
   logic              i_rvalid;
   logic [DATA_W-1:0] i_rdata;
   logic              d_req;
   logic              d_we;
   logic [ADDR_W-1:0] d_addr;
   logic [DATA_W-1:0] d_wdata;
   logic              d_gnt;
   logic              d_rvalid;
   logic [DATA_W-1:0] d_rdata;
   logic              flush;
   logic              m_req;
   logic              m_we;
   logic [ADDR_W-1:0] m_addr;
   logic [DATA_W-1:0] m_wdata;
   logic [DATA_W-1:0] m_rdata;
   logic              busy;

   int   total;
   int   bad;
   vec_t vecs[$];

   mem_port_arbiter #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LAT(2), .STARVE_MAX(3)
   ) dut (
      .clk(clk), .reset(reset),
      .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
      .flush(flush),
      .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata),
      .busy(busy)
   );

   // Free-running clock, rising edges at 5, 15, 25 ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // One comparison: counts it and reports a mismatch.
   task automatic checkOutput(input string name, input int row, input logic [31:0] actual,
                              input logic [31:0] expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s row=%0d actual=0x%0h expected=0x%0h", name, row, actual, expected);
      end
   endtask

   task automatic addRow(input logic rst, input logic iReq, input logic [31:0] iAddr,
                         input logic dReq, input logic dWe, input logic [31:0] dAddr,
                         input logic [31:0] dWdata, input logic fl, input logic [31:0] mRdata,
                         input logic [6:0] expFlags, input logic [31:0] expAddr,
                         input logic [31:0] expWdata, input logic [31:0] expRdata,
                         input logic [3:0] expStarve);
      vec_t v;
      v.rst = rst; v.iReq = iReq; v.iAddr = iAddr; v.dReq = dReq; v.dWe = dWe;
      v.dAddr = dAddr; v.dWdata = dWdata; v.flush = fl; v.mRdata = mRdata;
      v.expFlags = expFlags; v.expAddr = expAddr; v.expWdata = expWdata;
      v.expRdata = expRdata; v.expStarve = expStarve;
      vecs.push_back(v);
   endtask

   task automatic applyStimulus(input vec_t v);
      reset   = v.rst;
      i_req   = v.iReq;
      i_addr  = v.iAddr;
      d_req   = v.dReq;
      d_we    = v.dWe;
      d_addr  = v.dAddr;
      d_wdata = v.dWdata;
      flush   = v.flush;
      m_rdata = v.mRdata;
   endtask

   task automatic checkRow(input int row, input vec_t v);
      checkOutput("flags", row, 32'({i_gnt, i_rvalid, d_gnt, d_rvalid, m_req, m_we, busy}),
                  32'(v.expFlags));
      checkOutput("starve_cnt", row, 32'(dut.starveCnt_q), 32'(v.expStarve));
      if ((v.expFlags & F_MR) != 7'd0) checkOutput("m_addr", row, m_addr, v.expAddr);
      if ((v.expFlags & F_MW) != 7'd0) checkOutput("m_wdata", row, m_wdata, v.expWdata);
      if ((v.expFlags & F_IR) != 7'd0) checkOutput("i_rdata", row, i_rdata, v.expRdata);
      if ((v.expFlags & F_DR) != 7'd0) checkOutput("d_rdata", row, d_rdata, v.expRdata);
   endtask

   initial begin
      int lat;
      logic seen;
      total = 0;
      bad   = 0;
      reset = 1'b1; i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_we = 1'b0;
      d_addr = '0; d_wdata = '0; flush = 1'b0; m_rdata = '0;

      // rst iReq iAddr dReq dWe dAddr dWdata flush mRdata | flags addr wdata rdata starve
      // Reset with both requests held, then contention on release.
      addRow(1, 1, 'h10, 1, 0, 'h100, 0, 0, 0, 7'd0, 0, 0, 0, 0);
      addRow(1, 1, 'h10, 1, 0, 'h100, 0, 0, 0, 7'd0, 0, 0, 0, 0);
      addRow(0, 1, 'h10, 1, 0, 'h100, 0, 0, 0, F_DG|F_MR, 'h100, 0, 0, 0);
      addRow(0, 1, 'h10, 0, 0, 0, 0, 0, 0, F_BZ, 0, 0, 0, 1);
      addRow(0, 1, 'h10, 0, 0, 0, 0, 0, 'hDEAD0100, F_DR|F_IG|F_MR|F_BZ, 'h10, 0, 'hDEAD0100, 1);
      addRow(0, 0, 0, 0, 0, 0, 0, 0, 0, F_BZ, 0, 0, 0, 0);
      addRow(0, 0, 0, 0, 0, 0, 0, 0, 'hE3A00001, F_IR|F_BZ, 0, 0, 'hE3A00001, 0);
      addRow(0, 0, 0, 0, 0, 0, 0, 0, 0, 7'd0, 0, 0, 0, 0);
      // Single fetch.
      addRow(0, 1, 'h10, 0, 0, 0, 0, 0, 0, F_IG|F_MR, 'h10, 0, 0, 0);
      addRow(0, 0, 0, 0, 0, 0, 0, 0, 0, F_BZ, 0, 0, 0, 0);
      addRow(0, 0, 0, 0, 0, 0, 0, 0, 'hE3A00001, F_IR|F_BZ, 0, 0, 'hE3A00001, 0);
      addRow(0, 0, 0, 0, 0, 0, 0, 0, 0, 7'd0, 0, 0, 0, 0);
      // Starvation: fetch held against a store stream.
      addRow(0, 1, 'h20, 1, 1, 'h200, 'hA, 0, 0, F_DG|F_MR|F_MW, 'h200, 'hA, 0, 0);
      addRow(0, 1, 'h20, 1, 1, 'h204, 'hB, 0, 0, F_DG|F_MR|F_MW, 'h204, 'hB, 0, 1);
      addRow(0, 1, 'h20, 1, 1, 'h208, 'hC, 0, 0, F_DG|F_MR|F_MW, 'h208, 'hC, 0, 2);
      addRow(0, 1, 'h20, 1, 1, 'h20C, 'hD, 0, 0, F_IG|F_MR, 'h20, 0, 0, 3);
      addRow(0, 0, 0, 1, 1, 'h20C, 'hD, 0, 0, F_BZ, 0, 0, 0, 0);
      addRow(0, 0, 0, 1, 1, 'h20C, 'hD, 0, 'h11112222, F_IR|F_DG|F_MR|F_MW|F_BZ, 'h20C, 'hD, 'h11112222, 0);
      addRow(0, 0, 0, 0, 0, 0, 0, 0, 0, 7'd0, 0, 0, 0, 0);
      // Flush of an in-flight fetch, new fetch, then D traffic under flush.
      addRow(0, 1, 'h30, 0, 0, 0, 0, 0, 0, F_IG|F_MR, 'h30, 0, 0, 0);
      addRow(0, 0, 0, 0, 0, 0, 0, 1, 0, F_BZ, 0, 0, 0, 0);
      addRow(0, 1, 'h40, 0, 0, 0, 0, 0, 'h33333333, F_IG|F_MR|F_BZ, 'h40, 0, 0, 0);
      addRow(0, 0, 0, 1, 0, 'h300, 0, 0, 0, F_BZ, 0, 0, 0, 0);
      addRow(0, 0, 0, 1, 0, 'h300, 0, 0, 'h44444444, F_IR|F_DG|F_MR|F_BZ, 'h300, 0, 'h44444444, 0);
      addRow(0, 0, 0, 0, 0, 0, 0, 1, 0, F_BZ, 0, 0, 0, 0);
      addRow(0, 0, 0, 0, 0, 0, 0, 1, 'h30030030, F_DR|F_BZ, 0, 0, 'h30030030, 0);
      addRow(0, 0, 0, 0, 0, 0, 0, 0, 0, 7'd0, 0, 0, 0, 0);
      // Reset in the middle of a load.
      addRow(0, 0, 0, 1, 0, 'h400, 0, 0, 0, F_DG|F_MR, 'h400, 0, 0, 0);
      addRow(1, 0, 0, 0, 0, 0, 0, 0, 'h9, 7'd0, 0, 0, 0, 0);
      addRow(0, 0, 0, 0, 0, 0, 0, 0, 'h55555555, 7'd0, 0, 0, 0, 0);
      addRow(0, 0, 0, 0, 0, 0, 0, 0, 0, 7'd0, 0, 0, 0, 0);
      // Fetch, store and flush together: D wins, no starvation step.
      addRow(0, 1, 'h50, 1, 1, 'h500, 'hE, 1, 0, F_DG|F_MR|F_MW, 'h500, 'hE, 0, 0);
      addRow(0, 0, 0, 0, 0, 0, 0, 0, 0, 7'd0, 0, 0, 0, 0);

      foreach (vecs[r]) begin
         @(negedge clk);
         applyStimulus(vecs[r]);
         #1;
         checkRow(r, vecs[r]);
      end

      // Back-to-back loads: one grant every MEM_LAT cycles, data returned in
      // the same cycle as the next grant.
      for (int k = 0; k < 7; k++) begin
         @(negedge clk);
         reset = 1'b0; flush = 1'b0; i_req = 1'b0;
         d_req = (k < 6); d_we = 1'b0; d_addr = 32'h600; m_rdata = 32'h600 + 32'(k);
         #1;
         checkOutput("stream d_gnt", 100 + k, 32'(d_gnt), 32'((k % 2 == 0) && (k < 6)));
         checkOutput("stream d_rvalid", 100 + k, 32'(d_rvalid), 32'((k % 2 == 0) && (k > 0)));
         if ((k % 2 == 0) && (k > 0)) checkOutput("stream d_rdata", 100 + k, d_rdata, 32'h600 + 32'(k));
      end

      // Bounded latency measurement for a single load.
      @(negedge clk);
      d_req = 1'b0; m_rdata = 32'h77;
      @(negedge clk);
      d_req = 1'b1; d_addr = 32'h700;
      #1;
      checkOutput("lat d_gnt", 200, 32'(d_gnt), 32'd1);
      lat  = 0;
      seen = 1'b0;
      for (int n = 1; n <= 8 && !seen; n++) begin
         @(negedge clk);
         d_req = 1'b0;
         #1;
         if (d_rvalid) begin
            seen = 1'b1;
            lat  = n;
         end
      end
      checkOutput("lat seen", 201, 32'(seen), 32'd1);
      checkOutput("lat cycles", 202, 32'(lat), 32'd2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
